// File: rtl/dcfeb_crc_gen.sv
// dcfeb_crc_gen: CRC-32 generator for the DCFEB DAQ readout path.
// Accumulates an MSB-first CRC over qualified 16-bit data words and emits a
// one-clock-delayed word stream: data passthrough, then the low and high
// halves of the final CRC, then zero words.
module dcfeb_crc_gen #(
  parameter logic [31:0] POLY     = 32'h04C11DB7,
  parameter logic [31:0] INIT_VAL = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d,
  input  logic        calc,
  input  logic        init,
  input  logic        d_valid,
  output logic [31:0] crc_reg,
  output logic [15:0] crc
);

  localparam logic [1:0] PH_DATA = 2'd0;
  localparam logic [1:0] PH_LOW  = 2'd1;
  localparam logic [1:0] PH_DONE = 2'd2;

  // One word of CRC update, d[15] shifted in first, no reflection.
  function automatic logic [31:0] next_crc(input logic [31:0] c_in,
                                           input logic [15:0] w);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[31] ^ w[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h00000000);
    end
    return c;
  endfunction

  logic [31:0] crc_reg_q, crc_reg_d;
  logic [15:0] crc_q, crc_d;
  logic [1:0]  ph_q, ph_d;
  logic        data_cyc_s;

  assign data_cyc_s = calc & d_valid;

  // Next CRC register: init beats data, data advances, otherwise hold.
  always_comb begin
    crc_reg_d = crc_reg_q;
    if (init) begin
      crc_reg_d = INIT_VAL;
    end else if (data_cyc_s) begin
      crc_reg_d = next_crc(crc_reg_q, d);
    end else begin
      crc_reg_d = crc_reg_q;
    end
  end

  // Next output word: passthrough on data, otherwise append CRC halves then zeros.
  always_comb begin
    crc_d = crc_q;
    if (data_cyc_s) begin
      crc_d = d;
    end else if (d_valid) begin
      case (ph_q)
        PH_DATA: crc_d = crc_reg_q[15:0];
        PH_LOW:  crc_d = crc_reg_q[31:16];
        PH_DONE: crc_d = 16'h0000;
        default: crc_d = 16'h0000;
      endcase
    end else begin
      crc_d = crc_q;
    end
  end

  // Next append phase: cleared by init or data, advanced by non-data valid slots.
  always_comb begin
    ph_d = ph_q;
    if (init || data_cyc_s) begin
      ph_d = PH_DATA;
    end else if (d_valid) begin
      case (ph_q)
        PH_DATA: ph_d = PH_LOW;
        PH_LOW:  ph_d = PH_DONE;
        PH_DONE: ph_d = PH_DONE;
        default: ph_d = PH_DONE;
      endcase
    end else begin
      ph_d = ph_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_reg_q <= INIT_VAL;
      crc_q     <= 16'h0000;
      ph_q      <= PH_DATA;
    end else begin
      crc_reg_q <= crc_reg_d;
      crc_q     <= crc_d;
      ph_q      <= ph_d;
    end
  end

  assign crc_reg = crc_reg_q;
  assign crc     = crc_q;

endmodule

// File: tb/tb_dcfeb_crc_gen.sv
// tb_dcfeb_crc_gen: directed-vector scoreboard bench for dcfeb_crc_gen.
// Each stimulus cycle pushes the expected post-edge outputs into a queue; a
// monitor on the falling edge pops and compares them.
module tb_dcfeb_crc_gen;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  bit          clk = 1'b0;
  logic        reset;
  logic [15:0] d;
  logic        calc;
  logic        init;
  logic        d_valid;
  logic [31:0] crc_reg;
  logic [15:0] crc;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] reg_v;
    logic [15:0] crc_v;
    bit          chk_reg;
    bit          chk_crc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  dcfeb_crc_gen #(.POLY(POLY), .INIT_VAL(32'h00000000)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .calc    (calc),
    .init    (init),
    .d_valid (d_valid),
    .crc_reg (crc_reg),
    .crc     (crc)
  );

  always #5 clk = ~clk;

  // Bit-serial reference: long division of the word bitstream, MSB first, init 0.
  function automatic logic [31:0] crc_model(input logic [15:0] words[$]);
    logic [31:0] c;
    logic        top;
    c = 32'h00000000;
    foreach (words[k]) begin
      for (int b = 15; b >= 0; b--) begin
        top = c[31];
        c   = c << 1;
        if (top != words[k][b]) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  // Monitor: compare outputs after every rising edge that has an expectation queued.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk_reg) begin
        n_vec++;
        if (crc_reg !== e.reg_v) begin
          n_miss++;
          $display("FAIL %s crc_reg: got %08h expected %08h", e.name, crc_reg, e.reg_v);
        end
      end
      if (e.chk_crc) begin
        n_vec++;
        if (crc !== e.crc_v) begin
          n_miss++;
          $display("FAIL %s crc: got %04h expected %04h", e.name, crc, e.crc_v);
        end
      end
    end
  end

  task automatic step(input bit rst, input bit dv, input bit cl, input bit in,
                      input logic [15:0] dd, input logic [31:0] er,
                      input logic [15:0] ec, input bit cr, input bit cc,
                      input string nm);
    exp_t e;
    reset   = rst;
    d_valid = dv;
    calc    = cl;
    init    = in;
    d       = dd;
    e.reg_v = er; e.crc_v = ec; e.chk_reg = cr; e.chk_crc = cc; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ev_words[$];

  // Full event: init, all data words, then the append slots with one gap.
  task automatic run_event(input string tag);
    logic [15:0] pre[$];
    logic [31:0] m;
    pre = {};
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0, 16'h0, 1'b1, 1'b0, {tag, "_init"});
    foreach (ev_words[k]) begin
      pre.push_back(ev_words[k]);
      m = crc_model(pre);
      step(1'b0, 1'b1, 1'b1, 1'b0, ev_words[k], m, ev_words[k], 1'b1, 1'b1,
           $sformatf("%s_w%0d", tag, k));
    end
    m = crc_model(ev_words);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h5A5A, m, m[15:0],  1'b1, 1'b1, {tag, "_lo"});
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, m, m[15:0],  1'b1, 1'b1, {tag, "_gap"});
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, m, m[31:16], 1'b1, 1'b1, {tag, "_hi"});
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h4321, m, 16'h0000, 1'b1, 1'b1, {tag, "_zero"});
  endtask

  initial begin
    logic [15:0] gw[$];
    logic [31:0] gm;
    int          wait_cnt;

    ev_words = {16'h9001, 16'h9000, 16'h907F, 16'h9000, 16'hA07F, 16'hA010,
                16'hA000, 16'hA001};
    for (int k = 1; k <= 8; k++) ev_words.push_back(16'h6000 + 16'(k));
    for (int k = 1; k <= 8; k++) ev_words.push_back(16'h7000 + 16'(k));
    ev_words.push_back(16'hF001);
    ev_words.push_back(16'hF000);
    ev_words.push_back(16'hF000);
    ev_words.push_back(16'hF000);
    ev_words.push_back(16'hE000);
    ev_words.push_back(16'hE010);
    ev_words.push_back(16'hE1CD);
    ev_words.push_back(16'hEA3F);

    // Reset held with random data/controls, then released with controls low.
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 16'($urandom),
           32'h0, 16'h0, 1'b1, 1'b1, "reset");
    for (int k = 0; k < 2; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 32'h0, 16'h0, 1'b1, 1'b1, "post_reset");

    // Single-word vectors.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,        16'h0000, 1'b1, 1'b1, "sw1_init");
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 32'h04C11DB7, 16'h0001, 1'b1, 1'b1, "sw_0001");
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,        16'h0001, 1'b1, 1'b1, "sw2_init");
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 32'h09823B6E, 16'h0002, 1'b1, 1'b1, "sw_0002");
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,        16'h0002, 1'b1, 1'b1, "sw3_init");
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0,        16'h0000, 1'b1, 1'b1, "sw_0000");

    // Gap invariance, including calc high without d_valid.
    gw = {16'h9001};
    gm = crc_model(gw);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0, 16'h0000, 1'b1, 1'b0, "gap_init");
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h9001, gm, 16'h9001, 1'b1, 1'b1, "gap_w0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, gm, 16'h9001, 1'b1, 1'b1, "gap_hold_a");
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, gm, 16'h9001, 1'b1, 1'b1, "gap_hold_b");
    gw.push_back(16'h9000);
    gm = crc_model(gw);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h9000, gm, 16'h9000, 1'b1, 1'b1, "gap_w1");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h2222, gm, 16'h9000, 1'b1, 1'b1, "gap_hold_c");
    gw.push_back(16'h907F);
    gm = crc_model(gw);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h907F, gm, 16'h907F, 1'b1, 1'b1, "gap_w2");

    // Full event with appended CRC halves.
    run_event("ev1");

    // init wins over a simultaneous data word; that word is excluded.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,        16'h0000, 1'b1, 1'b0, "prio_init");
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 32'h04C11DB7, 16'h0001, 1'b1, 1'b1, "prio_w0");
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h0,        16'h0000, 1'b1, 1'b0, "prio_both");
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 32'h09823B6E, 16'h0002, 1'b1, 1'b1, "prio_after");

    // Mid-event reset discards state; a fresh event reproduces the CRC.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0, 16'h0000, 1'b1, 1'b0, "mid_init");
    gw = {16'h9001};
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h9001, crc_model(gw), 16'h9001, 1'b1, 1'b1, "mid_w0");
    gw.push_back(16'h9000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h9000, crc_model(gw), 16'h9000, 1'b1, 1'b1, "mid_w1");
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h907F, 32'h0, 16'h0000, 1'b1, 1'b1, "mid_reset");
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b1, 1'b1, "mid_ph_cleared");
    run_event("ev2");

    // Drain the scoreboard with a bounded wait.
    reset = 1'b0; d_valid = 1'b0; calc = 1'b0; init = 1'b0; d = 16'h0000;
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dcfeb_crc_gen.md
# dcfeb_crc_gen

CRC-32 generator for the DCFEB DAQ readout path, run over the 16-bit data words of one event. The module accumulates a CRC over qualified words between an `init` pulse and the end of the `calc` window. It also produces a one-cycle-delayed output word stream: data words are passed through, then the two CRC halves are appended. It sits between the event word formatter and the link serializer.

## Interface
Parameters:
- POLY, 32'h04C11DB7, CRC-32 generator polynomial, normal (non-reflected) form.
- INIT_VAL, 32'h00000000, value loaded into the CRC register by `init` and by `reset`.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (CMS clock domain); all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- d  in  16  data word.
- calc  in  1  `d` is a data word to be included in the CRC.
- init  in  1  reload the CRC register with INIT_VAL.
- d_valid  in  1  `d` slot is valid this cycle.
- crc_reg  out  32  running CRC register (registered).
- crc  out  16  output word stream: delayed data, then CRC halves (registered).

## Operation
- **Bit order:** each 16-bit word is processed MSB first: d[15] first, d[0] last.
  - Update: for i = 15 down to 0, fb = crc_reg[31] ^ d[i]; crc_reg = {crc_reg[30:0], 1'b0} ^ (fb ? POLY : 0).
  - This is implemented as one combinational 16-bit-parallel step per clock.
- **No output processing:** no final XOR and no bit reflection.
- **crc_reg update priority per edge:**
  - reset: crc_reg <= INIT_VAL.
  - else init: crc_reg <= INIT_VAL; `d` is ignored even if calc & d_valid.
  - else calc & d_valid: crc_reg <= next_crc(crc_reg, d).
  - else: hold.
- **Append phase counter** `ph` (2 bits): 0 = data, 1 = low half sent, 2 = both halves sent.
  - Cleared by reset, init, and any cycle with calc & d_valid.
- **crc output update per edge:**
  - reset: crc <= 0.
  - d_valid & calc: crc <= d (data passthrough).
  - d_valid & !calc & ph=0: crc <= crc_reg[15:0]; ph <= 1.
  - d_valid & !calc & ph=1: crc <= crc_reg[31:16]; ph <= 2.
  - d_valid & !calc & ph=2: crc <= 16'h0000; ph holds at 2.
  - !d_valid: crc and ph hold.
- **CRC halves:** crc_reg is frozen while calc=0, so both appended halves belong to the same final CRC.
- **calc without d_valid:** calc=1 with d_valid=0 is not a data cycle; the CRC holds.

## Timing
- **CRC latency:** crc_reg reflects word N one clock after the edge that samples word N. After the last data word, crc_reg is final on the next cycle.
- **Stream latency:** crc lags its source by one clock. The first CRC half appears on crc one clock after the first d_valid & !calc cycle, i.e. immediately after the last passthrough data word.
- **init timing:** init is one cycle, normally the cycle before the first data word. Data may follow back-to-back: an init at edge k and data at edge k+1 starts from INIT_VAL.
- **Reset outputs:** crc_reg=INIT_VAL, crc=0, ph=0. Reset asserted mid-event discards all accumulated state.
- **Throughput:** one word per clock, no stalls. Gaps with d_valid=0 are allowed anywhere and leave all state unchanged.

## Test plan
- **Reset:** reset held 5 clocks with random d/calc → crc_reg=0x00000000, crc=0x0000; they stay there after release with all controls low.
- **Single word 0x0001:** init, then one word 16'h0001 with calc=d_valid=1 → crc_reg=0x04C11DB7.
  - Repeat with 16'h0002 → 0x09823B6E.
  - Repeat with 16'h0000 → 0x00000000.
- **Gap invariance:** init, then words 0x9001, 0x9000, 0x907F with d_valid=0 gaps inserted → crc_reg equals a software CRC-32 model (MSB-first, init 0, no final XOR) computed on the same three words without gaps.
- **Full event and append:**
  - Stimulus: init; 32 words (0x9001…0xEA3F sequence: 9001, 9000, 907F, 9000, A07F, A010, A000, A001, 6001–6008, 7001–7008, F001, F000×3, E000, E010, E1CD, EA3F) with calc=1; then two cycles calc=0, d_valid=1; then a third such cycle.
  - crc echoes each data word one clock late.
  - crc then shows model[15:0], then model[31:16], then 0x0000.
- **init priority:** init and calc & d_valid asserted together with d=0xFFFF → crc_reg=INIT_VAL; that word is excluded from the CRC.
- **Mid-event reset:** reset during the data phase → crc_reg=0 and crc=0 on the next cycle. A fresh init plus the event reproduces the expected CRC.
